// File: rtl/ras_ckpt_if.sv
// Bundle of prediction-path signals between the fetch/decode logic and the
// checkpointed return address stack.
interface ras_ckpt_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int CKPT_LOG2  = 2
);
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic                  ckpt_alloc;
  logic [CKPT_LOG2-1:0]  ckpt_id;
  logic                  ckpt_full;
  logic                  ckpt_free;
  logic                  restore;
  logic [CKPT_LOG2-1:0]  restore_id;
  logic [ADDR_WIDTH-1:0] pred_addr;
  logic                  pred_valid;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output push, pop, push_addr, ckpt_alloc, ckpt_free, restore, restore_id,
    input  ckpt_id, ckpt_full, pred_addr, pred_valid, count
  );

  modport slave (
    input  push, pop, push_addr, ckpt_alloc, ckpt_free, restore, restore_id,
    output ckpt_id, ckpt_full, pred_addr, pred_valid, count
  );
endinterface

// File: rtl/ras_ckpt.sv
// Circular return address stack with a ring of snapshots (pointer, occupancy,
// top entry). A flush restores one snapshot exactly and releases that slot
// together with every younger one.
module ras_ckpt #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int CKPT_LOG2  = 2
) (
  input logic     clk,
  input logic     rst,
  ras_ckpt_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NCKPT = 1 << CKPT_LOG2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [CKPT_LOG2-1:0]  cid_t;
  typedef logic [CKPT_LOG2:0]    occ_t;

  addr_t entries_q [DEPTH];
  ptr_t  tp_q, tp_d;
  cnt_t  cnt_q, cnt_d;
  logic  wr_en;
  ptr_t  wr_idx;
  addr_t wr_data;

  // Snapshot slots hold data only; their validity is tracked by the ring.
  ptr_t  slot_tp_q  [NCKPT];
  cnt_t  slot_cnt_q [NCKPT];
  addr_t slot_top_q [NCKPT];

  cid_t  head_q, head_d;
  cid_t  tail_q, tail_d;
  occ_t  occ_q, occ_d;
  logic  full;
  logic  snap_en;
  logic  free_en;

  assign full           = (occ_q == occ_t'(NCKPT));
  assign bus.ckpt_full  = full;
  assign bus.ckpt_id    = tail_q;
  assign bus.pred_addr  = entries_q[tp_q];
  assign bus.pred_valid = (cnt_q != '0);
  assign bus.count      = cnt_q;

  // Stack next state: restore overrides push/pop; push+pop replaces the top.
  always_comb begin
    tp_d    = tp_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tp_q;
    wr_data = bus.push_addr;
    if (bus.restore) begin
      tp_d    = slot_tp_q[bus.restore_id];
      cnt_d   = slot_cnt_q[bus.restore_id];
      wr_en   = 1'b1;
      wr_idx  = slot_tp_q[bus.restore_id];
      wr_data = slot_top_q[bus.restore_id];
    end else if (bus.push && bus.pop) begin
      wr_en   = 1'b1;
    end else if (bus.push) begin
      tp_d    = tp_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = tp_q + 1'b1;
      if (cnt_q != cnt_t'(DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (bus.pop) begin
      // Pointer still moves on underflow to keep circular alignment.
      tp_d    = tp_q - 1'b1;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Checkpoint ring next state. On restore the ring is first truncated to
  // the slots older than restore_id; a same-cycle free then applies only if
  // anything is left, so restoring the oldest slot always empties the ring.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    snap_en = 1'b0;
    free_en = 1'b0;
    if (bus.restore) begin
      tail_d = bus.restore_id;
      occ_d  = occ_t'(cid_t'(bus.restore_id - head_q));
      if (bus.ckpt_free && (occ_d != '0)) begin
        head_d = head_q + 1'b1;
        occ_d  = occ_d - 1'b1;
      end
    end else begin
      snap_en = bus.ckpt_alloc && !full;
      free_en = bus.ckpt_free && (occ_q != '0);
      if (snap_en) tail_d = tail_q + 1'b1;
      if (free_en) head_d = head_q + 1'b1;
      occ_d = occ_q + occ_t'(snap_en) - occ_t'(free_en);
    end
  end

  // Stack state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
      if (wr_en) entries_q[wr_idx] <= wr_data;
    end
  end

  // Ring pointers and in-flight count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Snapshot capture of the pre-update stack state.
  always_ff @(posedge clk) begin
    if (snap_en && !rst) begin
      slot_tp_q[tail_q]  <= tp_q;
      slot_cnt_q[tail_q] <= cnt_q;
      slot_top_q[tail_q] <= entries_q[tp_q];
    end
  end
endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: stack push/pop/wrap, coroutine swap,
// checkpoint ring allocation, free and restore.
module tb_ras_ckpt;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ras_ckpt_if bus ();
  ras_ckpt dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_addr = '0;
    bus.ckpt_alloc = 1'b0; bus.ckpt_free = 1'b0;
    bus.restore = 1'b0; bus.restore_id = '0;
  endtask

  task automatic cyc(input logic pu, input logic po, input logic [31:0] a,
                     input logic al, input logic fr, input logic rs,
                     input logic [1:0] rid);
    bus.push = pu; bus.pop = po; bus.push_addr = a;
    bus.ckpt_alloc = al; bus.ckpt_free = fr;
    bus.restore = rs; bus.restore_id = rid;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();
    chk("rst_pred_addr",  bus.pred_addr, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_count",      bus.count, 0);
    chk("rst_ckpt_full",  bus.ckpt_full, 0);
    chk("rst_ckpt_id",    bus.ckpt_id, 0);

    // Basic push/pop
    cyc(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, 0, 32'h200, 0, 0, 0, 0);
    cyc(1, 0, 32'h300, 0, 0, 0, 0);
    chk("push3_pred", bus.pred_addr, 32'h300);
    chk("push3_count", bus.count, 3);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("pop2_pred", bus.pred_addr, 32'h100);
    chk("pop2_count", bus.count, 1);
    chk("pop2_valid", bus.pred_valid, 1);

    // Overflow wrap: 17 pushes into 16 entries
    do_reset();
    for (int k = 0; k < 17; k++) cyc(1, 0, 32'h1000 + 4 * k, 0, 0, 0, 0);
    chk("ovf_count", bus.count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), bus.pred_addr, 32'h1040 - 4 * i);
      cyc(0, 1, 0, 0, 0, 0, 0);
    end
    chk("drain_count", bus.count, 0);
    chk("drain_valid", bus.pred_valid, 0);
    // Underflow pop keeps count at 0 but moves the pointer
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("udf_count", bus.count, 0);
    cyc(1, 0, 32'hA0, 0, 0, 0, 0);
    chk("after_udf_pred", bus.pred_addr, 32'hA0);
    chk("after_udf_count", bus.count, 1);
    // Coroutine swap
    cyc(1, 1, 32'hB0, 0, 0, 0, 0);
    chk("swap_pred", bus.pred_addr, 32'hB0);
    chk("swap_count", bus.count, 1);

    // Snapshot with same-cycle pop, then restore
    do_reset();
    cyc(1, 0, 32'h10, 0, 0, 0, 0);
    cyc(1, 0, 32'h20, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    chk("alloc_pop_pred", bus.pred_addr, 32'h10);
    chk("alloc_pop_id", bus.ckpt_id, 1);
    cyc(1, 0, 32'h99, 0, 0, 0, 0);
    chk("spec_push_pred", bus.pred_addr, 32'h99);
    chk("spec_push_count", bus.count, 2);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("rest0_pred", bus.pred_addr, 32'h20);
    chk("rest0_count", bus.count, 2);
    chk("rest0_full", bus.ckpt_full, 0);
    chk("rest0_id", bus.ckpt_id, 0);

    // Ring fill, drop when full, free
    do_reset();
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("free_empty_id", bus.ckpt_id, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_id%0d", i), bus.ckpt_id, i);
      chk($sformatf("fill_notfull%0d", i), bus.ckpt_full, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
    end
    chk("fill_full", bus.ckpt_full, 1);
    chk("fill_id_wrap", bus.ckpt_id, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("drop_full", bus.ckpt_full, 1);
    chk("drop_id", bus.ckpt_id, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("free_full", bus.ckpt_full, 0);
    chk("free_id", bus.ckpt_id, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("realloc_id", bus.ckpt_id, 1);
    chk("realloc_full", bus.ckpt_full, 1);

    // Restore a middle slot with same-cycle free and ignored push
    do_reset();
    cyc(1, 0, 32'h10, 0, 0, 0, 0);
    cyc(1, 0, 32'h20, 1, 0, 0, 0);
    cyc(1, 0, 32'h30, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 32'h77, 0, 0, 0, 0);
    chk("pre_rest_pred", bus.pred_addr, 32'h77);
    chk("pre_rest_count", bus.count, 3);
    chk("pre_rest_id", bus.ckpt_id, 3);
    cyc(1, 0, 32'hEE, 0, 1, 1, 1);
    chk("rest1_pred", bus.pred_addr, 32'h20);
    chk("rest1_count", bus.count, 2);
    chk("rest1_id", bus.ckpt_id, 1);
    chk("rest1_full", bus.ckpt_full, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    chk("empty_ring_3", bus.ckpt_full, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("empty_ring_4", bus.ckpt_full, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("post_pop_pred", bus.pred_addr, 32'h10);

    // Reset wins over a same-cycle push
    rst = 1'b1; bus.push = 1'b1; bus.push_addr = 32'h55;
    @(posedge clk); #1;
    rst = 1'b0; idle_inputs();
    chk("rstwin_count", bus.count, 0);
    chk("rstwin_pred", bus.pred_addr, 0);
    chk("rstwin_full", bus.ckpt_full, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
